// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_t;

  // Width of a port index; kept at least 1 so single-bit buses stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the per-port request streams and the merged output stream.
interface axis_rr_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned T_DATA_WIDTH = 32,
  localparam int unsigned IdW         = id_width(N_PORTS)
) ();

  logic [N_PORTS-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [N_PORTS-1:0]                   s_valid_i;
  logic [N_PORTS-1:0]                   s_last_i;
  logic [N_PORTS-1:0]                   s_ready_o;
  logic [T_DATA_WIDTH-1:0]              m_data_o;
  logic                                 m_valid_o;
  logic                                 m_last_o;
  logic [IdW-1:0]                       m_id_o;
  logic                                 m_ready_i;
  logic [N_PORTS-1:0]                   grant_o;

  // Arbiter view: it is the sink of the requesters and the source of the merged stream.
  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o, grant_o
  );

  // Environment view: drives the requesters and consumes the merged stream.
  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o, grant_o
  );

endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Rotate-priority selector: first asserted request at or above ptr_i, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdW = id_width(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o,
  output logic            any_o
);

  int unsigned    pos;
  logic [IdW-1:0] pos_idx;

  // Scan NReq positions starting at ptr_i; explicit wrap keeps non-power-of-2 counts correct.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NReq) pos = pos - NReq;
      pos_idx = IdW'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of N_PORTS AXI-Stream requesters into one registered, id-tagged stream.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned T_DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN    = 16
) (
  input logic              clk,
  input logic              reset,
  axis_rr_arbiter_if.slave bus
);

  localparam int unsigned IdW  = id_width(N_PORTS);
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  arb_state_t              state_q, state_d;
  logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [N_PORTS-1:0]      grant_q, grant_d;
  logic [IdW-1:0]          gidx_q, gidx_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [IdW-1:0]          m_id_q, m_id_d;

  logic [N_PORTS-1:0] pick_gnt;
  logic [IdW-1:0]     pick_idx;
  logic               pick_any;
  logic               out_free;
  logic               accept;
  logic [N_PORTS-1:0] s_ready;

  rr_pick #(
    .NReq (N_PORTS)
  ) u_pick (
    .req_i (bus.s_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Arbitration FSM, beat acceptance and output register next-state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_id_d     = m_id_q;
    s_ready    = '0;
    accept     = 1'b0;
    // Output slot is free when empty or being popped this cycle.
    out_free   = !m_valid_q || bus.m_ready_i;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d    = pick_gnt;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        s_ready = grant_q & {N_PORTS{out_free}};
        accept  = bus.s_valid_i[gidx_q] && out_free;
        if (accept) begin
          m_data_d   = bus.s_data_i[gidx_q];
          m_last_d   = bus.s_last_i[gidx_q];
          m_id_d     = gidx_q;
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (bus.s_last_i[gidx_q] || (beat_cnt_q == CntW'(BURST_LEN - 1))) begin
            state_d    = StIdle;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (gidx_q == IdW'(N_PORTS - 1)) ? '0 : gidx_q + IdW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A drained output with nothing new to load goes empty, in either state.
    if (out_free && !accept) m_valid_d = 1'b0;
    else if (accept) m_valid_d = 1'b1;
  end

  // Control and tag state, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      gidx_q     <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_id_q     <= m_id_d;
    end
  end

  // Data payload register; qualified by m_valid so it needs no reset.
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_data_o  = m_data_q;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_last_o  = m_last_q;
  assign bus.m_id_o    = m_id_q;
  assign bus.grant_o   = grant_q;

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one AXI-Stream sink, typically the write side of an `axis_fifo_fr` instance, between `N_PORTS` requesting streams. A grant is held until the requester ends its packet or reaches a burst limit, and then it rotates to the next port. The output is fully registered and every beat is tagged with its source port, so a downstream block can demultiplex the merged stream.

## Interface
- `N_PORTS`, 4: number of requesters, must be ≥ 2.
- `T_DATA_WIDTH`, 32: data width.
- `BURST_LEN`, 16: maximum beats per grant, must be ≥ 1.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `s_data_i`  in  `[N_PORTS-1:0][T_DATA_WIDTH-1:0]`  per-port data.
- `s_valid_i`  in  `N_PORTS`  per-port valid.
- `s_last_i`  in  `N_PORTS`  per-port end-of-packet.
- `s_ready_o`  out  `N_PORTS`  per-port ready; at most one bit is high at a time.
- `m_data_o`  out  `T_DATA_WIDTH`  registered data.
- `m_valid_o`  out  1  registered valid.
- `m_last_o`  out  1  registered copy of the source `s_last_i`.
- `m_id_o`  out  `$clog2(N_PORTS)`  registered source port index.
- `m_ready_i`  in  1  downstream ready.
- `grant_o`  out  `N_PORTS`  one-hot current grant; zero in IDLE.

## Operation
- Two-state FSM: IDLE and GRANT.
- **IDLE**
  - If any `s_valid_i` bit is high, select the first valid port searching upward from `rr_ptr`, wrapping modulo `N_PORTS`.
  - Register the selection into `grant_o`, clear `beat_cnt`, and go to GRANT.
  - With no valid input, stay in IDLE.
  - All `s_ready_o` bits are 0 in IDLE.
- **GRANT**
  - Define `out_free = !m_valid_o | m_ready_i`.
  - `s_ready_o[g] = out_free` for the granted port `g`; all other bits are 0.
  - A beat is accepted when `s_valid_i[g] & s_ready_o[g]`. On acceptance the output register loads data, last and id, `m_valid_o` goes to 1, and `beat_cnt` increments.
  - If `out_free` is high and no beat is accepted, `m_valid_o` goes to 0.
  - The grant ends on an accepted beat with `s_last_i[g]=1`, or on an accepted beat with `beat_cnt == BURST_LEN-1`. On grant end: go to IDLE, set `rr_ptr = (g+1) mod N_PORTS`, clear `grant_o`.
  - A burst cut by `BURST_LEN` does not set `m_last_o`. The rest of that packet arrives in a later grant, still tagged with the same `m_id_o`.
  - If `s_valid_i[g]` is low, hold the grant indefinitely. There is no timeout.
- **Arithmetic**
  - `beat_cnt` is `$clog2(BURST_LEN+1)` bits wide and never exceeds `BURST_LEN-1` when stored.
  - The `rr_ptr` wrap is explicit: when `g == N_PORTS-1` the next value is 0. This must hold for non-power-of-2 `N_PORTS`.
- **Simultaneous events**
  - New requests arriving in GRANT are ignored until IDLE.
  - A final-beat accept and a downstream pop in the same cycle are both honoured. The output register reloads with no bubble.
- **Reset (synchronous, any state)**
  - State goes to IDLE, and `rr_ptr`, `beat_cnt`, `grant_o`, `s_ready_o` go to 0.
  - `m_valid_o`, `m_last_o` and `m_id_o` go to 0.
  - `m_data_o` is not reset.
  - Any in-flight beat is discarded.

## Timing
- Arbitration latency is 1 cycle: a request at IDLE cycle t gives `grant_o` and `s_ready_o` at t+1.
- First output: a beat accepted at cycle t appears on `m_valid_o`/`m_data_o` at t+1.
- Throughput is 1 beat/cycle within a grant while `m_ready_i` stays high.
- Each grant change costs one IDLE bubble cycle.
- `s_ready_o` depends combinationally on `m_ready_i` and `m_valid_o`. There is no combinational path from `s_valid_i` to `s_ready_o`.
- Output stability: while `m_valid_o & !m_ready_i`, the data, last and id outputs must hold.

## Structure
- Shared package `axis_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - function `id_width(n)`.
- Sub-module `rr_pick`: combinational rotate-priority selector.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, index, and an `any` flag.
  - Reusable by future schedulers.

## Test plan
- **Single port, short packet:** `N_PORTS=4`; port 2 sends 3 beats (last on the 3rd) with `m_ready_i=1`. Expect `m_id_o=2` on all beats, `m_last_o` only on beat 3, first `m_valid_o` 2 cycles after the request, then IDLE with `rr_ptr=3`.
- **Fairness:** all 4 ports always valid with 1-beat packets. Expected output id sequence is 0,1,2,3,0,1…, with one bubble between grants.
- **Burst cut:** `BURST_LEN=4`; port 1 sends a 10-beat packet while port 3 is also valid. Expected output: 4 beats id1, then 4 beats id3 (if port 3's packet is long), then the next 4 beats of id1. `m_last_o` is set only on port 1's 10th beat.
- **Backpressure:** hold `m_ready_i=0` for 5 cycles mid-packet. Expect `m_data_o` stable, `s_ready_o=0`, no beat lost or duplicated; compare the full stream against a scoreboard.
- **Reset mid-grant:** assert `reset` for 1 cycle during beat 2 of 5. The next cycle must show `m_valid_o=0`, `grant_o=0`, `s_ready_o=0`; arbitration then restarts from port 0.
- **Non-power-of-2:** `N_PORTS=3`; port 2 ends a packet. Expect `rr_ptr` to wrap to 0 and never take the value 3.
